// File: rtl/ssd_scan_driver.sv
// Scan controller for a 4-digit seven-segment display. It steps through the
// digits one refresh slot at a time and presents each digit's nibble, its
// index and an active-low anode vector to the segment decoder. New display
// words are staged and committed only at frame boundaries, or immediately
// while the display is off, so a frame never mixes two words.
module ssd_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic        lz_en,
  output logic [3:0]  num,
  output logic [1:0]  sel,
  output logic [3:0]  an,
  output logic        blank,
  output logic        frame
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic {OFF = 1'b0, SCAN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       staged_q, staged_d;
  logic [15:0]       shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic [1:0]        sel_d;
  logic [3:0]        num_d;
  logic [3:0]        an_d;
  logic              blank_d;
  logic              frame_d;
  logic              tick;
  logic              wrap;
  logic              commit;
  logic              dig_blanked;

  // Nibble of digit k within a 16-bit display word.
  function automatic logic [3:0] digit_nibble(input logic [1:0] k,
                                              input logic [15:0] word);
    logic [3:0] res;
    case (k)
      2'd0:    res = word[3:0];
      2'd1:    res = word[7:4];
      2'd2:    res = word[11:8];
      default: res = word[15:12];
    endcase
    return res;
  endfunction

  // Active-low anode pattern that lights only digit k.
  function automatic logic [3:0] digit_anode(input logic [1:0] k);
    return ~(4'b0001 << k);
  endfunction

  // Leading-zero suppression: digit k is dark when it and every digit above
  // it are zero. The rightmost digit always stays lit so a value of 0 shows.
  function automatic logic digit_blanked(input logic [1:0] k,
                                         input logic [15:0] word,
                                         input logic lz);
    logic res;
    case (k)
      2'd0:    res = 1'b0;
      2'd1:    res = lz && (word[15:4] == 12'h000);
      2'd2:    res = lz && (word[15:8] == 8'h00);
      default: res = lz && (word[15:12] == 4'h0);
    endcase
    return res;
  endfunction

  // State register: OFF while disabled, SCAN while cycling digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OFF;
    else        state_q <= state_d;
  end

  // Next state, prescaler, update path and next output values.
  always_comb begin
    state_d     = en ? SCAN : OFF;
    tick        = (state_q == SCAN) && en && (cnt_q == LAST);
    wrap        = tick && (sel == 2'd3);
    // While disabled a pending word is committed straight away; while
    // scanning it waits for the 3->0 wrap so the whole frame is coherent.
    commit      = pending_q && (wrap || !en || (state_q == OFF));
    shadow_d    = commit ? staged_q : shadow_q;
    staged_d    = load ? digits : staged_q;
    pending_d   = load || (pending_q && !commit);
    frame_d     = wrap;
    cnt_d       = cnt_q;
    sel_d       = sel;
    num_d       = num;
    an_d        = an;
    blank_d     = blank;
    dig_blanked = 1'b0;
    if (!en) begin
      cnt_d   = '0;
      sel_d   = 2'd0;
      num_d   = shadow_d[3:0];
      an_d    = 4'b1111;
      blank_d = 1'b1;
    end else if ((state_q == OFF) || tick) begin
      // Entering SCAN or finishing a slot: restart the prescaler and register
      // all outputs for the new digit together so they never disagree.
      cnt_d       = '0;
      sel_d       = (state_q == OFF) ? 2'd0 : sel + 2'd1;
      dig_blanked = digit_blanked(sel_d, shadow_d, lz_en);
      num_d       = digit_nibble(sel_d, shadow_d);
      an_d        = dig_blanked ? 4'b1111 : digit_anode(sel_d);
      blank_d     = dig_blanked;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      staged_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      sel       <= 2'd0;
      num       <= 4'h0;
      an        <= 4'b1111;
      blank     <= 1'b1;
      frame     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      staged_q  <= staged_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      sel       <= sel_d;
      num       <= num_d;
      an        <= an_d;
      blank     <= blank_d;
      frame     <= frame_d;
    end
  end

endmodule
